// File: rtl/bus_io_bridge_pkg.sv
// Shared constants for bus_io_bridge: I/O window layout, status bit positions
// and a helper that packs a {flag, pending} status pair.
package bus_io_bridge_pkg;

  localparam logic [7:0] IO_BASE_DEFAULT = 8'hF8;
  localparam int         IO_WINDOW       = 8;

  localparam logic [2:0] OFS_OUT_DATA = 3'd0;
  localparam logic [2:0] OFS_OUT_STAT = 3'd1;
  localparam logic [2:0] OFS_IN_DATA  = 3'd2;
  localparam logic [2:0] OFS_IN_STAT  = 3'd3;
  localparam logic [2:0] OFS_SW       = 3'd4;
  localparam logic [2:0] OFS_LED      = 3'd5;

  // Both status registers share a layout: bit 0 = word pending, bit 1 = sticky error.
  localparam int STAT_PEND_BIT = 0;
  localparam int STAT_FLAG_BIT = 1;

  function automatic logic [1:0] pack_stat(input logic flag, input logic pend);
    logic [1:0] s;
    s = '0;
    s[STAT_PEND_BIT] = pend;
    s[STAT_FLAG_BIT] = flag;
    return s;
  endfunction

endpackage

// File: rtl/bus_data_ram.sv
// Data RAM below the I/O window: synchronous write, asynchronous read.
module bus_data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 248,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing storage would need a per-word reset
  // network and the CPU expects RAM contents to survive a bridge reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_io_bridge.sv
// CPU slave bridge: decodes the word address into data RAM and an 8-word I/O
// window with an output handshake channel, strobed input channel, switches and LEDs.
module bus_io_bridge
  import bus_io_bridge_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT),
  parameter int                SW_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_r,
  input  logic              bus_w,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_strobe,
  input  logic [SW_W-1:0]   sw,
  output logic [SW_W-1:0]   led
);

  localparam int RAM_AW = $clog2(int'(IO_BASE));

  logic [ADDR_W-1:0] io_ofs_full;
  logic [2:0]        ofs;
  logic              in_ram, in_io;
  logic [DATA_W-1:0] ram_rdata;

  logic              overrun, in_ready, in_lost;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        strobe_sync;
  logic [SW_W-1:0]   sw_meta, sw_sync;

  logic out_xfer, in_rise;
  logic wr_out_data, wr_led, rd_out_stat, rd_in_data, rd_in_stat;

  assign io_ofs_full = bus_addr - IO_BASE;
  assign ofs         = io_ofs_full[2:0];
  assign in_ram      = bus_addr < IO_BASE;
  assign in_io       = !in_ram && (io_ofs_full < ADDR_W'(IO_WINDOW));

  assign wr_out_data = bus_w && in_io && (ofs == OFS_OUT_DATA);
  assign wr_led      = bus_w && in_io && (ofs == OFS_LED);
  assign rd_out_stat = bus_r && in_io && (ofs == OFS_OUT_STAT);
  assign rd_in_data  = bus_r && in_io && (ofs == OFS_IN_DATA);
  assign rd_in_stat  = bus_r && in_io && (ofs == OFS_IN_STAT);

  assign out_xfer = out_valid && out_ready;
  // strobe_sync[1] is the synchronized strobe, [2] its one-cycle-old copy.
  assign in_rise  = strobe_sync[1] && !strobe_sync[2];

  bus_data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (int'(IO_BASE)),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (bus_w && in_ram),
    .addr  (bus_addr[RAM_AW-1:0]),
    .wdata (bus_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: defaulting the output before the case keeps every path assigned,
    // so no latch is inferred for the unlisted offsets.
    bus_rdata = '0;
    if (bus_r) begin
      if (in_ram) begin
        bus_rdata = ram_rdata;
      end else if (in_io) begin
        case (ofs)
          OFS_OUT_STAT: bus_rdata = DATA_W'(pack_stat(overrun, out_valid));
          OFS_IN_DATA:  bus_rdata = in_data;
          OFS_IN_STAT:  bus_rdata = DATA_W'(pack_stat(in_lost, in_ready));
          OFS_SW:       bus_rdata = DATA_W'(sw_sync);
          OFS_LED:      bus_rdata = DATA_W'(led);
          default:      bus_rdata = '0;
        endcase
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // pre-edge values; later statements override earlier ones (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      overrun     <= 1'b0;
      led         <= '0;
      in_ready    <= 1'b0;
      in_lost     <= 1'b0;
      in_data     <= '0;
      strobe_sync <= '0;
      sw_meta     <= '0;
      sw_sync     <= '0;
    end else begin
      strobe_sync <= {strobe_sync[1:0], in_strobe};
      sw_meta     <= sw;
      sw_sync     <= sw_meta;

      if (rd_out_stat) overrun <= 1'b0;
      if (wr_out_data) begin
        if (!out_valid || out_xfer) begin
          out_data  <= bus_wdata;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      if (rd_in_data) in_ready <= 1'b0;
      if (rd_in_stat) in_lost  <= 1'b0;
      if (in_rise) begin
        if (!in_ready || rd_in_data) begin
          in_data  <= in_value;
          in_ready <= 1'b1;
        end else begin
          in_lost <= 1'b1;
        end
      end

      if (wr_led) led <= bus_wdata[SW_W-1:0];
    end
  end

endmodule

// File: tb/tb_bus_io_bridge.sv
// Self-checking bench for bus_io_bridge: directed scenarios plus randomized
// traffic compared against a reference model of the bus-visible behaviour.
module tb_bus_io_bridge;

  localparam logic [7:0] A_OUT_DATA = 8'hF8;
  localparam logic [7:0] A_OUT_STAT = 8'hF9;
  localparam logic [7:0] A_IN_DATA  = 8'hFA;
  localparam logic [7:0] A_IN_STAT  = 8'hFB;
  localparam logic [7:0] A_SW       = 8'hFC;
  localparam logic [7:0] A_LED      = 8'hFD;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_r, bus_w;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [31:0] in_value;
  logic        in_strobe;
  logic [7:0]  sw, led;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q [$];
  logic [31:0] ram_m [logic [7:0]];

  bus_io_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_r     (bus_r),
    .bus_w     (bus_w),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_value  (in_value),
    .in_strobe (in_strobe),
    .sw        (sw),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Records every word the consumer actually takes.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_w = 1'b1;
    tick();
    bus_w = 1'b0;
  endtask

  // Read that completes a clock edge, so read side effects take place.
  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus_addr = a; bus_r = 1'b1;
    #1 d = bus_rdata;
    tick();
    bus_r = 1'b0;
  endtask

  // Combinational look without letting an edge see the strobe.
  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    bus_addr = a; bus_r = 1'b1;
    #1 d = bus_rdata;
    bus_r = 1'b0;
  endtask

  task automatic pulse_strobe(input logic [31:0] v);
    in_strobe = 1'b0;
    repeat (3) tick();
    in_value  = v;
    in_strobe = 1'b1;
    repeat (3) tick();
    in_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data: got=%h exp=0", out_data); end
    total++; if (led !== 8'h0) begin bad++; $display("FAIL rst_led: got=%h exp=0", led); end
    rst = 1'b0;
    tick();
    peek(A_OUT_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_out_stat: got=%h exp=0", d); end
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_in_stat: got=%h exp=0", d); end
    peek(A_IN_DATA, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_in_data: got=%h exp=0", d); end
    tick();
  endtask

  task automatic test_ram();
    logic [7:0]  a;
    logic [31:0] d, old_v, new_v;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 247));
      if (a == 8'h10) a = 8'h11;
      d = $urandom;
      bus_write(a, d);
      ram_m[a] = d;
    end
    bus_write(8'h10, 32'h1234_5678);
    ram_m[8'h10] = 32'h1234_5678;
    foreach (ram_m[k]) begin
      peek(k, d);
      total++; if (d !== ram_m[k]) begin bad++; $display("FAIL ram_rd[%h]: got=%h exp=%h", k, d, ram_m[k]); end
      tick();
    end
    peek(8'hFE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_rd: got=%h exp=0", d); end
    bus_addr = 8'h10; bus_r = 1'b0;
    #1;
    total++; if (bus_rdata !== 32'h0) begin bad++; $display("FAIL rdata_idle: got=%h exp=0", bus_rdata); end
    tick();
    old_v = $urandom; new_v = ~old_v;
    bus_write(8'h20, old_v);
    bus_addr = 8'h20; bus_wdata = new_v; bus_r = 1'b1; bus_w = 1'b1;
    #1 d = bus_rdata;
    total++; if (d !== old_v) begin bad++; $display("FAIL rw_same_cycle: got=%h exp=%h", d, old_v); end
    tick();
    bus_r = 1'b0; bus_w = 1'b0;
    ram_m[8'h20] = new_v;
    peek(8'h20, d);
    total++; if (d !== new_v) begin bad++; $display("FAIL rw_after: got=%h exp=%h", d, new_v); end
    tick();
  endtask

  task automatic test_out_channel();
    logic [31:0] d;
    out_ready = 1'b0;
    bus_write(A_OUT_DATA, 32'hA5);
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA5) begin bad++; $display("FAIL out_load: got v=%b d=%h exp v=1 d=a5", out_valid, out_data); end
    bus_write(A_OUT_DATA, 32'h5A);
    bus_read(A_OUT_STAT, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL out_stat_ovr: got=%h exp=3", d); end
    bus_read(A_OUT_STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL out_stat_clr: got=%h exp=1", d); end
    total++; if (out_data !== 32'hA5) begin bad++; $display("FAIL out_keep: got=%h exp=a5", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL out_xfer: got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    logic        m_valid, m_ovr, rdy, do_w, xfer;
    logic [31:0] m_data;
    logic [31:0] exp_q [$];
    out_ready = 1'b0;
    bus_write(A_OUT_DATA, 32'h1);
    got_q.delete();
    out_ready = 1'b1;
    bus_write(A_OUT_DATA, 32'h2);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin bad++; $display("FAIL b2b_load: got v=%b d=%h exp v=1 d=2", out_valid, out_data); end
    peek(A_OUT_STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL b2b_stat: got=%h exp=1", d); end
    total++; if (got_q.size() != 1 || got_q[0] !== 32'h1) begin bad++; $display("FAIL b2b_xfer: got n=%0d exp one word 1", got_q.size()); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized traffic: every accepted store must leave exactly once, in order.
    got_q.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    for (int i = 0; i < 60; i++) begin
      rdy  = 1'($urandom_range(0, 1));
      do_w = ($urandom_range(0, 2) == 0);
      d    = $urandom;
      xfer = m_valid && rdy;
      if (xfer) exp_q.push_back(m_data);
      if (do_w && (!m_valid || xfer)) begin m_data = d; m_valid = 1'b1; end
      else if (do_w)                  m_ovr = 1'b1;
      else if (xfer)                  m_valid = 1'b0;
      out_ready = rdy;
      if (do_w) bus_write(A_OUT_DATA, d);
      else      tick();
      total++; if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin bad++; $display("FAIL rnd_out[%0d]: got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, m_valid, m_data); end
    end
    out_ready = 1'b0;
    peek(A_OUT_STAT, d);
    e = {30'b0, m_ovr, m_valid};
    total++; if (d !== e) begin bad++; $display("FAIL rnd_out_stat: got=%h exp=%h", d, e); end
    if (m_valid) exp_q.push_back(m_data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_out_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_out_word[%0d]: got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    bus_read(A_OUT_STAT, d);
  endtask

  task automatic test_input();
    logic [31:0] d, x, y, first, e;
    int          n;
    in_strobe = 1'b0; in_value = 32'h77;
    repeat (3) tick();
    in_strobe = 1'b1;
    tick(); tick();
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL in_early: got=%h exp=0", d); end
    tick();
    in_strobe = 1'b0;
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL in_capture: got=%h exp=1", d); end
    pulse_strobe(32'h88);
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL in_lost: got=%h exp=3", d); end
    tick();
    bus_read(A_IN_DATA, d);
    total++; if (d !== 32'h77) begin bad++; $display("FAIL in_data: got=%h exp=77", d); end
    bus_read(A_IN_STAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL in_stat_after_rd: got=%h exp=2", d); end
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL in_stat_clr: got=%h exp=0", d); end
    tick();

    // Read of IN_DATA on the same edge as a new capture.
    x = $urandom; y = $urandom;
    pulse_strobe(x);
    repeat (3) tick();
    in_value = y; in_strobe = 1'b1;
    tick(); tick();
    bus_read(A_IN_DATA, d);
    in_strobe = 1'b0;
    total++; if (d !== x) begin bad++; $display("FAIL in_rd_cap_old: got=%h exp=%h", d, x); end
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL in_rd_cap_stat: got=%h exp=1", d); end
    peek(A_IN_DATA, d);
    total++; if (d !== y) begin bad++; $display("FAIL in_rd_cap_new: got=%h exp=%h", d, y); end
    tick();
    bus_read(A_IN_DATA, d);

    // Random bursts of one or two captures before the CPU reads.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 2);
      first = '0;
      for (int p = 0; p < n; p++) begin
        x = $urandom;
        if (p == 0) first = x;
        pulse_strobe(x);
      end
      e = {30'b0, (n > 1), 1'b1};
      peek(A_IN_STAT, d);
      total++; if (d !== e) begin bad++; $display("FAIL rnd_in_stat[%0d]: got=%h exp=%h", it, d, e); end
      tick();
      bus_read(A_IN_DATA, d);
      total++; if (d !== first) begin bad++; $display("FAIL rnd_in_data[%0d]: got=%h exp=%h", it, d, first); end
      bus_read(A_IN_STAT, d);
      e = {30'b0, (n > 1), 1'b0};
      total++; if (d !== e) begin bad++; $display("FAIL rnd_in_stat2[%0d]: got=%h exp=%h", it, d, e); end
      peek(A_IN_STAT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rnd_in_clr[%0d]: got=%h exp=0", it, d); end
      tick();
    end
  endtask

  task automatic test_sw_led();
    logic [31:0] d;
    logic [7:0]  s, l;
    sw = 8'h3C;
    tick(); tick();
    peek(A_SW, d);
    total++; if (d !== 32'h3C) begin bad++; $display("FAIL sw_3c: got=%h exp=3c", d); end
    tick();
    for (int i = 0; i < 4; i++) begin
      s  = 8'($urandom);
      sw = s;
      tick(); tick();
      peek(A_SW, d);
      total++; if (d !== {24'b0, s}) begin bad++; $display("FAIL sw_rnd[%0d]: got=%h exp=%h", i, d, s); end
      tick();
    end
    bus_write(A_LED, 32'hFF);
    total++; if (led !== 8'hFF) begin bad++; $display("FAIL led_ff: got=%h exp=ff", led); end
    l = 8'($urandom);
    bus_write(A_LED, {24'hABCDEF, l});
    total++; if (led !== l) begin bad++; $display("FAIL led_rnd: got=%h exp=%h", led, l); end
    peek(A_LED, d);
    total++; if (d !== {24'b0, l}) begin bad++; $display("FAIL led_rd: got=%h exp=%h", d, l); end
    tick();
    bus_write(8'hFE, $urandom);
    bus_write(8'hFF, $urandom);
    bus_write(A_SW, $urandom);
    total++; if (led !== l || out_valid !== 1'b0) begin bad++; $display("FAIL reserved_wr: got led=%h v=%b exp led=%h v=0", led, out_valid, l); end
    peek(8'hFE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_rd6: got=%h exp=0", d); end
    peek(A_SW, d);
    total++; if (d !== {24'b0, sw}) begin bad++; $display("FAIL sw_ro: got=%h exp=%h", d, sw); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    out_ready = 1'b0;
    bus_write(A_OUT_DATA, $urandom);
    pulse_strobe($urandom);
    tick();
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h1 || out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst: got in_stat=%h v=%b exp 1/1", d, out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || led !== 8'h0) begin bad++; $display("FAIL mid_rst_out: got v=%b d=%h led=%h exp all 0", out_valid, out_data, led); end
    peek(A_OUT_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_out_stat: got=%h exp=0", d); end
    peek(A_IN_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_in_stat: got=%h exp=0", d); end
    tick();
    peek(A_IN_DATA, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_in_data: got=%h exp=0", d); end
    peek(8'h10, d);
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL ram_survives: got=%h exp=12345678", d); end
    tick();
  endtask

  initial begin
    rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_r = 1'b0; bus_w = 1'b0;
    out_ready = 1'b0; in_value = '0; in_strobe = 1'b0; sw = '0;
    test_reset();
    test_ram();
    test_out_channel();
    test_back_to_back();
    test_input();
    test_sw_led();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
